// File: rtl/adc_calc_scheduler.sv
// rtl/adc_calc_scheduler.sv - shares one FP gain/offset pipeline across ADC channels; define ADC_SCHED_PRIO_CH0_EN for strict channel-0 priority
module adc_calc_scheduler #(
  parameter int N_CH    = 10,
  parameter int CH_W    = $clog2(N_CH),
  parameter int CREDITS = 8
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [N_CH*32-1:0]  i_raw_data,
  input  logic [N_CH-1:0]     i_raw_valid,
  input  logic [N_CH*32-1:0]  i_gain,
  input  logic [N_CH*32-1:0]  i_offset,
  output logic [95:0]         o_op_tdata,
  output logic [CH_W-1:0]     o_op_tuser,
  output logic                o_op_tvalid,
  input  logic                i_op_tready,
  input  logic [31:0]         i_res_tdata,
  input  logic [CH_W-1:0]     i_res_tuser,
  input  logic                i_res_tvalid,
  output logic [N_CH*32-1:0]  o_ch_data,
  output logic [N_CH-1:0]     o_ch_valid,
  output logic [N_CH-1:0]     o_overrun,
  input  logic                i_overrun_clr,
  output logic                o_bad_tag,
  output logic [3:0]          o_inflight
);

  typedef enum logic {ST_IDLE, ST_HOLD} state_t;

  localparam logic [3:0] CRED_MAX = 4'(CREDITS);

  state_t              state_q, state_d;
  logic [N_CH-1:0]     pend_q, pend_d;
  logic [31:0]         smp_q [N_CH];
  logic [31:0]         smp_d [N_CH];
  logic [CH_W-1:0]     ptr_q, ptr_d;
  logic [95:0]         op_tdata_q, op_tdata_d;
  logic [CH_W-1:0]     op_tuser_q, op_tuser_d;
  logic [3:0]          inflight_q, inflight_d;
  logic [N_CH*32-1:0]  ch_data_q, ch_data_d;
  logic [N_CH-1:0]     ch_valid_q, ch_valid_d;
  logic [N_CH-1:0]     overrun_q, overrun_d;
  logic                bad_tag_q, bad_tag_d;

  logic                hs;
  logic                load;
  logic                prio0;
  logic                rr_found;
  logic [CH_W-1:0]     rr_grant;
  logic [CH_W-1:0]     grant;
  logic [95:0]         grant_word;
  logic                res_ok;

  // Arbiter: first pending channel after the last granted one, wrapping
  always_comb begin
    rr_found = 1'b0;
    rr_grant = '0;
    for (int i = 1; i <= N_CH; i++) begin
      if (!rr_found && pend_q[(int'(ptr_q) + i) % N_CH]) begin
        rr_found = 1'b1;
        rr_grant = CH_W'((int'(ptr_q) + i) % N_CH);
      end
    end
`ifdef ADC_SCHED_PRIO_CH0_EN
    prio0 = pend_q[0];
`else
    prio0 = 1'b0;
`endif
    grant = prio0 ? '0 : rr_grant;
    grant_word = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (grant == CH_W'(k)) begin
        grant_word = {i_offset[32*k +: 32], i_gain[32*k +: 32], smp_q[k]};
      end
    end
  end

  // Credit accounting and issue-register control
  always_comb begin
    hs         = (state_q == ST_HOLD) && i_op_tready;
    inflight_d = inflight_q;
    if (hs && !i_res_tvalid) begin
      inflight_d = inflight_q + 4'd1;
    end else if (!hs && i_res_tvalid && (inflight_q != 4'd0)) begin
      inflight_d = inflight_q - 4'd1;
    end
    // Compare against the post-update count so the op leaving this cycle
    // and the one loaded behind it never overcommit the pipeline.
    load = ((state_q == ST_IDLE) || i_op_tready) && (|pend_q) && (inflight_d < CRED_MAX);

    state_d    = state_q;
    op_tdata_d = op_tdata_q;
    op_tuser_d = op_tuser_q;
    ptr_d      = ptr_q;
    if (load) begin
      state_d    = ST_HOLD;
      op_tdata_d = grant_word;
      op_tuser_d = grant;
      if (!prio0) begin
        ptr_d = grant;
      end
    end else if (hs) begin
      state_d = ST_IDLE;
    end
  end

  // Per-channel sample capture, pending flags and overrun detection
  always_comb begin
    pend_d    = pend_q;
    overrun_d = overrun_q;
    for (int k = 0; k < N_CH; k++) begin
      smp_d[k] = smp_q[k];
    end
    for (int k = 0; k < N_CH; k++) begin
      if (i_raw_valid[k]) begin
        smp_d[k] = i_raw_data[32*k +: 32];
      end
      // A channel granted this cycle ships its old sample, so a new strobe is not an overrun.
      pend_d[k]    = (pend_q[k] && !(load && (grant == CH_W'(k)))) || i_raw_valid[k];
      overrun_d[k] = (overrun_q[k] && !i_overrun_clr) ||
                     (i_raw_valid[k] && pend_q[k] && !(load && (grant == CH_W'(k))));
    end
  end

  // Result routing back to per-channel registers
  always_comb begin
    res_ok     = (int'(i_res_tuser) < N_CH);
    ch_data_d  = ch_data_q;
    ch_valid_d = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (i_res_tvalid && res_ok && (i_res_tuser == CH_W'(k))) begin
        ch_data_d[32*k +: 32] = i_res_tdata;
        ch_valid_d[k]         = 1'b1;
      end
    end
    bad_tag_d = (bad_tag_q && !i_overrun_clr) || (i_res_tvalid && !res_ok);
  end

  // State registers; reset drops all pending and in-flight work
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      pend_q     <= '0;
      ptr_q      <= CH_W'(N_CH - 1);
      op_tdata_q <= '0;
      op_tuser_q <= '0;
      inflight_q <= '0;
      ch_data_q  <= '0;
      ch_valid_q <= '0;
      overrun_q  <= '0;
      bad_tag_q  <= 1'b0;
      for (int k = 0; k < N_CH; k++) begin
        smp_q[k] <= '0;
      end
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      ptr_q      <= ptr_d;
      op_tdata_q <= op_tdata_d;
      op_tuser_q <= op_tuser_d;
      inflight_q <= inflight_d;
      ch_data_q  <= ch_data_d;
      ch_valid_q <= ch_valid_d;
      overrun_q  <= overrun_d;
      bad_tag_q  <= bad_tag_d;
      for (int k = 0; k < N_CH; k++) begin
        smp_q[k] <= smp_d[k];
      end
    end
  end

  assign o_op_tdata  = op_tdata_q;
  assign o_op_tuser  = op_tuser_q;
  assign o_op_tvalid = (state_q == ST_HOLD);
  assign o_ch_data   = ch_data_q;
  assign o_ch_valid  = ch_valid_q;
  assign o_overrun   = overrun_q;
  assign o_bad_tag   = bad_tag_q;
  assign o_inflight  = inflight_q;

endmodule

// File: tb/tb_adc_calc_scheduler.sv
// tb/tb_adc_calc_scheduler.sv - scoreboard bench for adc_calc_scheduler
module tb_adc_calc_scheduler;

  localparam int N_CH = 10;
  localparam int CH_W = 4;

  typedef struct packed {
    logic [CH_W-1:0] tag;
    logic [95:0]     data;
  } op_t;

  typedef struct packed {
    logic [CH_W-1:0] tag;
    logic [31:0]     data;
  } res_t;

  logic               clk = 1'b0;
  logic               rst;
  logic [N_CH*32-1:0] raw_data;
  logic [N_CH-1:0]    raw_valid;
  logic [N_CH*32-1:0] gain;
  logic [N_CH*32-1:0] offset;
  logic [95:0]        op_tdata;
  logic [CH_W-1:0]    op_tuser;
  logic               op_tvalid;
  logic               op_tready;
  logic [31:0]        res_tdata;
  logic [CH_W-1:0]    res_tuser;
  logic               res_tvalid;
  logic [N_CH*32-1:0] ch_data;
  logic [N_CH-1:0]    ch_valid;
  logic [N_CH-1:0]    overrun;
  logic               overrun_clr;
  logic               bad_tag;
  logic [3:0]         inflight;

  int n_pass  = 0;
  int n_total = 0;
  int hs_cnt  = 0;
  int base;
  op_t  exp_op [$];
  res_t exp_res [$];
  op_t  mon_op;
  res_t mon_res;

  always #5 clk = ~clk;

  adc_calc_scheduler #(.N_CH(N_CH), .CH_W(CH_W), .CREDITS(8)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_raw_data(raw_data), .i_raw_valid(raw_valid),
    .i_gain(gain), .i_offset(offset),
    .o_op_tdata(op_tdata), .o_op_tuser(op_tuser), .o_op_tvalid(op_tvalid),
    .i_op_tready(op_tready),
    .i_res_tdata(res_tdata), .i_res_tuser(res_tuser), .i_res_tvalid(res_tvalid),
    .o_ch_data(ch_data), .o_ch_valid(ch_valid), .o_overrun(overrun),
    .i_overrun_clr(overrun_clr), .o_bad_tag(bad_tag), .o_inflight(inflight)
  );

  task automatic check(input string name, input logic [319:0] act, input logic [319:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, act, req);
  endtask

  function automatic logic [31:0] gain_of(input int ch);
    return (ch == 3) ? 32'h35A0_0000 : 32'h3F80_0000 + 32'(ch);
  endfunction

  function automatic logic [31:0] off_of(input int ch);
    return (ch == 3) ? 32'hC120_0000 : 32'h4100_0000 + 32'(ch);
  endfunction

  function automatic op_t mk_op(input int ch, input logic [31:0] smp);
    op_t o;
    o.tag  = CH_W'(ch);
    o.data = {off_of(ch), gain_of(ch), smp};
    return o;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe1(input int ch, input logic [31:0] smp);
    raw_data[32*ch +: 32] = smp;
    raw_valid[ch] = 1'b1;
    tick();
    raw_valid = '0;
  endtask

  task automatic strobe_mask(input logic [N_CH-1:0] mask, input logic [31:0] smp_base);
    for (int k = 0; k < N_CH; k++) raw_data[32*k +: 32] = smp_base + 32'(k);
    raw_valid = mask;
    tick();
    raw_valid = '0;
  endtask

  task automatic send_res(input int tag, input logic [31:0] d);
    res_tvalid = 1'b1;
    res_tuser  = CH_W'(tag);
    res_tdata  = d;
    tick();
    res_tvalid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    raw_valid = '0;
    res_tvalid = 1'b0;
    overrun_clr = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Monitor: every op handshake and every result pulse is popped against the scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (op_tvalid && op_tready) begin
        hs_cnt++;
        if (exp_op.size() == 0) begin
          n_total++;
          $display("FAIL op_unexpected: got tag %0d data %0h required no op", op_tuser, op_tdata);
        end else begin
          mon_op = exp_op.pop_front();
          check("op_tuser", 320'(op_tuser), 320'(mon_op.tag));
          check("op_tdata", 320'(op_tdata), 320'(mon_op.data));
        end
      end
      for (int k = 0; k < N_CH; k++) begin
        if (ch_valid[k]) begin
          if (exp_res.size() == 0) begin
            n_total++;
            $display("FAIL res_unexpected: got ch %0d data %0h required no result", k, ch_data[32*k +: 32]);
          end else begin
            mon_res = exp_res.pop_front();
            check("res_ch", 320'(k), 320'(mon_res.tag));
            check("res_data", 320'(ch_data[32*k +: 32]), 320'(mon_res.data));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  initial begin
    raw_data = '0; raw_valid = '0; op_tready = 1'b0;
    res_tdata = '0; res_tuser = '0; res_tvalid = 1'b0; overrun_clr = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      gain[32*k +: 32]   = gain_of(k);
      offset[32*k +: 32] = off_of(k);
    end
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state
    check("rst_tvalid", 320'(op_tvalid), 320'(0));
    check("rst_tdata", 320'(op_tdata), 320'(0));
    check("rst_inflight", 320'(inflight), 320'(0));
    check("rst_ch_data", ch_data, 320'(0));
    check("rst_flags", 320'({overrun, bad_tag, ch_valid}), 320'(0));

    // Single sample on ch3: latency and round trip
    op_tready = 1'b1;
    exp_op.push_back('{tag: 4'd3, data: {32'hC120_0000, 32'h35A0_0000, 32'h4000_0000}});
    strobe1(3, 32'h4000_0000);
    check("lat_c1_tvalid", 320'(op_tvalid), 320'(0));
    tick();
    check("lat_c2_tvalid", 320'(op_tvalid), 320'(1));
    check("lat_c2_tuser", 320'(op_tuser), 320'(3));
    tick();
    check("t1_tvalid_drop", 320'(op_tvalid), 320'(0));
    check("t1_inflight", 320'(inflight), 320'(1));
    exp_res.push_back('{tag: 4'd3, data: 32'hC11F_FFFF});
    send_res(3, 32'hC11F_FFFF);
    check("t1_ch_valid", 320'(ch_valid), 320'(10'b00_0000_1000));
    check("t1_ch_data3", 320'(ch_data[127:96]), 320'(32'hC11F_FFFF));
    tick();
    check("t1_ch_valid_pulse", 320'(ch_valid), 320'(0));
    check("t1_inflight_ret", 320'(inflight), 320'(0));

    // All channels at once: tags 0..9 back to back, results returned two cycles behind
    do_reset();
    op_tready = 1'b1;
    for (int k = 0; k < N_CH; k++) exp_op.push_back(mk_op(k, 32'h1000_0000 + 32'(k)));
    strobe_mask('1, 32'h1000_0000);
    tick();
    for (int c = 2; c <= 14; c++) begin
      if (c >= 4 && c <= 13) begin
        res_tvalid = 1'b1;
        res_tuser  = CH_W'(c - 4);
        res_tdata  = 32'h5000_0000 + 32'(c - 4);
        exp_res.push_back('{tag: CH_W'(c - 4), data: 32'h5000_0000 + 32'(c - 4)});
      end else begin
        res_tvalid = 1'b0;
      end
      if (c <= 11) begin
        check("rr_tvalid", 320'(op_tvalid), 320'(1));
        check("rr_tuser", 320'(op_tuser), 320'(c - 2));
      end
      tick();
    end
    res_tvalid = 1'b0;
    check("rr_inflight_end", 320'(inflight), 320'(0));

`ifdef ADC_SCHED_PRIO_CH0_EN
    // Channel 0 re-strobed every 3 cycles is granted on its next load
    begin
      int tags [8] = '{1, 2, 0, 3, 4, 0, 5, 6};
      do_reset();
      op_tready = 1'b1;
      for (int j = 0; j < 8; j++) begin
        if (j == 2) exp_op.push_back(mk_op(0, 32'hAAAA_0001));
        else if (j == 5) exp_op.push_back(mk_op(0, 32'hAAAA_0002));
        else exp_op.push_back(mk_op(tags[j], 32'h0900_0000 + 32'(tags[j])));
      end
      for (int c = 0; c <= 9; c++) begin
        raw_valid = '0;
        if (c == 0) begin
          for (int k = 0; k < N_CH; k++) raw_data[32*k +: 32] = 32'h0900_0000 + 32'(k);
          raw_valid = 10'b00_0111_1110;
        end else if (c == 2) begin
          raw_data[31:0] = 32'hAAAA_0001;
          raw_valid = 10'b1;
        end else if (c == 5) begin
          raw_data[31:0] = 32'hAAAA_0002;
          raw_valid = 10'b1;
        end
        if (c >= 2) check("prio_tuser", 320'(op_tuser), 320'(tags[c - 2]));
        tick();
      end
      raw_valid = '0;
    end
`endif

    // Backpressure hold, overrun on ch2, clear priority
    do_reset();
    op_tready = 1'b0;
    strobe1(5, 32'h3333_0005);
    tick();
    strobe1(2, 32'h2222_000A);
    strobe1(2, 32'h2222_000B);
    check("ovr_set", 320'(overrun), 320'(10'b00_0000_0100));
    for (int i = 0; i < 5; i++) begin
      check("hold_tvalid", 320'(op_tvalid), 320'(1));
      check("hold_tuser", 320'(op_tuser), 320'(5));
      check("hold_tdata", 320'(op_tdata), 320'({off_of(5), gain_of(5), 32'h3333_0005}));
      tick();
    end
    exp_op.push_back(mk_op(5, 32'h3333_0005));
    exp_op.push_back(mk_op(2, 32'h2222_000B));
    op_tready = 1'b1;
    tick();
    check("ovr_newest_tuser", 320'(op_tuser), 320'(2));
    check("ovr_newest_tdata", 320'(op_tdata), 320'({off_of(2), gain_of(2), 32'h2222_000B}));
    tick();
    check("ovr_drain_tvalid", 320'(op_tvalid), 320'(0));
    check("ovr_drain_inflight", 320'(inflight), 320'(2));
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    check("ovr_cleared", 320'(overrun), 320'(0));
    op_tready = 1'b0;
    strobe1(6, 32'h6666_0006);
    tick();
    strobe1(8, 32'h8888_000D);
    raw_data[32*8 +: 32] = 32'h8888_000E;
    raw_valid[8] = 1'b1;
    overrun_clr = 1'b1;
    tick();
    raw_valid = '0;
    overrun_clr = 1'b0;
    check("ovr_set_beats_clr", 320'(overrun), 320'(10'b01_0000_0000));
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    check("ovr_cleared2", 320'(overrun), 320'(0));
    exp_op.push_back(mk_op(6, 32'h6666_0006));
    exp_op.push_back(mk_op(8, 32'h8888_000E));
    op_tready = 1'b1;
    repeat (3) tick();
    check("ovr2_inflight", 320'(inflight), 320'(4));

    // Credit limit, one-result release, bad tag
    do_reset();
    op_tready = 1'b1;
    for (int k = 0; k < N_CH; k++) exp_op.push_back(mk_op(k, 32'h2000_0000 + 32'(k)));
    base = hs_cnt;
    strobe_mask('1, 32'h2000_0000);
    repeat (14) tick();
    check("cred_hs8", 320'(hs_cnt - base), 320'(8));
    check("cred_inflight8", 320'(inflight), 320'(8));
    check("cred_tvalid_off", 320'(op_tvalid), 320'(0));
    exp_res.push_back('{tag: 4'd0, data: 32'h6000_0000});
    send_res(0, 32'h6000_0000);
    repeat (4) tick();
    check("cred_hs9", 320'(hs_cnt - base), 320'(9));
    check("cred_inflight8b", 320'(inflight), 320'(8));
    check("cred_tvalid_off2", 320'(op_tvalid), 320'(0));
    send_res(12, 32'hDEAD_BEEF);
    check("bad_tag_set", 320'(bad_tag), 320'(1));
    check("bad_tag_no_valid", 320'(ch_valid), 320'(0));
    check("bad_tag_inflight", 320'(inflight), 320'(7));
    repeat (4) tick();
    check("bad_tag_hs10", 320'(hs_cnt - base), 320'(10));
    check("bad_tag_inflight8", 320'(inflight), 320'(8));
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    check("bad_tag_clr", 320'(bad_tag), 320'(0));

    // Reset with work in flight and pending
    do_reset();
    op_tready = 1'b1;
    for (int k = 0; k < 5; k++) exp_op.push_back(mk_op(k, 32'h7000_0000 + 32'(k)));
    strobe_mask(10'b01_1111_1111, 32'h7000_0000);
    tick();
    repeat (5) tick();
    op_tready = 1'b0;
    check("mid_inflight5", 320'(inflight), 320'(5));
    check("mid_held_tuser", 320'(op_tuser), 320'(5));
    rst = 1'b1;
    tick();
    check("mid_rst_op", 320'({op_tvalid, op_tuser, op_tdata}), 320'(0));
    check("mid_rst_ch_data", ch_data, 320'(0));
    check("mid_rst_flags", 320'({inflight, bad_tag, overrun, ch_valid}), 320'(0));
    rst = 1'b0;
    op_tready = 1'b1;
    base = hs_cnt;
    repeat (5) tick();
    check("mid_no_issue", 320'({op_tvalid, 32'(hs_cnt - base)}), 320'(0));
    exp_op.push_back(mk_op(4, 32'h4444_0004));
    strobe1(4, 32'h4444_0004);
    tick();
    check("post_rst_tvalid", 320'(op_tvalid), 320'(1));
    check("post_rst_tuser", 320'(op_tuser), 320'(4));
    repeat (2) tick();

    check("sb_ops_drained", 320'(exp_op.size()), 320'(0));
    check("sb_res_drained", 320'(exp_res.size()), 320'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
